// File: rtl/fft_pkg.sv
// Shared FFT front-end definitions: default frame geometry and the
// address bit-reversal helper used for decimation-in-time loading.
package fft_pkg;

  localparam int unsigned DATA_W_DEF   = 8;
  localparam int unsigned N_POINTS_DEF = 16;
  localparam int unsigned LOG2N        = $clog2(N_POINTS_DEF);
  localparam int unsigned MAX_LOG2N    = 6;

  // Reverse the low w bits of v; bits at and above w come back as zero.
  function automatic logic [MAX_LOG2N-1:0] bit_rev(input logic [MAX_LOG2N-1:0] v,
                                                   input int unsigned          w);
    logic [MAX_LOG2N-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < MAX_LOG2N; i++) begin
      if (i < w) r[3'(w - 1 - i)] = v[3'(i)];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_frame_ram.sv
// Two-bank sample store: one write port, one registered read port.
module fft_frame_ram #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned AW     = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic              wr_bank,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic              rd_bank,
  input  logic [AW-1:0]     rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  localparam int unsigned DEPTH = 2 ** (AW + 1);

  logic [DATA_W-1:0] mem [DEPTH];

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (we) mem[{wr_bank, wr_addr}] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     rd_data <= '0;
    else if (rd_en) rd_data <= mem[{rd_bank, rd_addr}];
  end

endmodule

// File: rtl/fft_frame_loader.sv
// Ping-pong frame loader feeding a downstream FFT core.
// Define FFT_BITREV_EN to store samples in bit-reversed address order.
module fft_frame_loader
  import fft_pkg::*;
#(
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned N_POINTS = N_POINTS_DEF
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        ena,
  input  logic [DATA_W-1:0]           sample_in,
  input  logic                        sample_stb,
  output logic                        frame_valid,
  input  logic                        frame_ack,
  input  logic [$clog2(N_POINTS)-1:0] rd_addr,
  output logic [DATA_W-1:0]           rd_data,
  output logic [$clog2(N_POINTS):0]   fill_count,
  output logic                        overflow
);

  localparam int unsigned AW = $clog2(N_POINTS);

  logic [1:0]    full;
  logic          wr_bank;
  logic          rd_bank;
  logic [AW-1:0] wr_idx;
  logic [AW-1:0] wr_addr;
  logic          accept;
  logic          drop;
  logic          last;
  logic          ack;

  assign accept = ena & sample_stb & ~full[wr_bank];
  assign drop   = ena & sample_stb &  full[wr_bank];
  assign last   = accept & (wr_idx == AW'(N_POINTS - 1));
  assign ack    = ena & frame_ack & full[rd_bank];

  assign frame_valid = full[rd_bank];
  assign fill_count  = {1'b0, wr_idx};

`ifdef FFT_BITREV_EN
  assign wr_addr = AW'(bit_rev(MAX_LOG2N'(wr_idx), AW));
`else
  assign wr_addr = wr_idx;
`endif

  // A completing write and an ack always target different banks, so both apply.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full     <= '0;
      wr_bank  <= 1'b0;
      rd_bank  <= 1'b0;
      wr_idx   <= '0;
      overflow <= 1'b0;
    end else begin
      if (accept) wr_idx <= wr_idx + AW'(1);
      if (last) begin
        full[wr_bank] <= 1'b1;
        wr_bank       <= ~wr_bank;
      end
      if (ack) begin
        full[rd_bank] <= 1'b0;
        rd_bank       <= ~rd_bank;
      end
      if (drop) overflow <= 1'b1;
    end
  end

  fft_frame_ram #(
    .DATA_W (DATA_W),
    .AW     (AW)
  ) u_ram (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (accept),
    .wr_bank (wr_bank),
    .wr_addr (wr_addr),
    .wr_data (sample_in),
    .rd_en   (ena),
    .rd_bank (rd_bank),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

endmodule
